// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: default IOBUS addresses,
// control-word bit positions and active-low hex glyphs ({g,f,e,d,c,b,a}).
package sseg_pkg;

  localparam logic [31:0] VALUE_ADDR_DEF = 32'h1100C010;
  localparam logic [31:0] CTRL_ADDR_DEF  = 32'h1100C014;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_BLANK  = 1;
  localparam int unsigned CTRL_DP_LSB = 2;

  localparam logic [3:0] AN_OFF   = 4'hF;
  localparam logic [7:0] SEGS_OFF = 8'hFF;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  always_comb begin
    segs = GLYPH_8;
    unique case (nibble)
      4'h0: segs = GLYPH_0;
      4'h1: segs = GLYPH_1;
      4'h2: segs = GLYPH_2;
      4'h3: segs = GLYPH_3;
      4'h4: segs = GLYPH_4;
      4'h5: segs = GLYPH_5;
      4'h6: segs = GLYPH_6;
      4'h7: segs = GLYPH_7;
      4'h8: segs = GLYPH_8;
      4'h9: segs = GLYPH_9;
      4'hA: segs = GLYPH_A;
      4'hB: segs = GLYPH_B;
      4'hC: segs = GLYPH_C;
      4'hD: segs = GLYPH_D;
      4'hE: segs = GLYPH_E;
      4'hF: segs = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// IOBUS-mapped four-digit seven-segment driver: holds a pending value and a
// control word, and scans the digits itself with frame-synchronous value updates.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 100000,
  parameter logic [31:0] VALUE_ADDR  = VALUE_ADDR_DEF,
  parameter logic [31:0] CTRL_ADDR   = CTRL_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] iobus_addr,
  input  logic [31:0] iobus_out,
  input  logic        iobus_wr,
  output logic [31:0] rd_data,
  output logic [7:0]  segs,
  output logic [3:0]  an
);

  localparam int unsigned      CNT_W   = $clog2(DIGIT_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_TICKS - 1);

  logic [15:0]      pend_val;
  logic [15:0]      disp_val;
  logic [5:0]       ctrl;
  logic [CNT_W-1:0] count;
  logic [1:0]       digit;
  logic             tick;
  logic             wr_value;
  logic             wr_ctrl;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic [3:0]       dp_mask;
  logic             upper_zero;
  logic             show;
  logic             unused_bits;

  assign tick        = (count == CNT_MAX);
  assign wr_value    = iobus_wr && (iobus_addr == VALUE_ADDR);
  assign wr_ctrl     = iobus_wr && (iobus_addr == CTRL_ADDR);
  assign dp_mask     = ctrl[CTRL_DP_LSB +: 4];
  assign unused_bits = ^iobus_out[31:16];

  // disp_val only reloads on the last tick of digit 3, so a frame never tears;
  // a value write on that same edge is seen one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val <= '0;
      disp_val <= '0;
      ctrl     <= '0;
      count    <= '0;
      digit    <= '0;
    end else begin
      if (wr_value) pend_val <= iobus_out[15:0];
      if (wr_ctrl)  ctrl     <= iobus_out[5:0];
      count <= tick ? '0 : count + 1'b1;
      if (tick) begin
        digit <= digit + 2'd1;
        if (digit == 2'd3) disp_val <= pend_val;
      end
    end
  end

  always_comb begin
    nibble = disp_val[{digit, 2'b00} +: 4];
  end

  sseg_hex_decode u_decode (
    .nibble (nibble),
    .segs   (glyph)
  );

  always_comb begin
    upper_zero = 1'b0;
    unique case (digit)
      2'd0: upper_zero = 1'b0;
      2'd1: upper_zero = (disp_val[15:4]  == '0);
      2'd2: upper_zero = (disp_val[15:8]  == '0);
      2'd3: upper_zero = (disp_val[15:12] == '0);
    endcase
    show = ctrl[CTRL_EN] && !(ctrl[CTRL_BLANK] && upper_zero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an   <= AN_OFF;
      segs <= SEGS_OFF;
    end else if (show) begin
      an   <= ~(4'b0001 << digit);
      segs <= {~dp_mask[digit], glyph};
    end else begin
      an   <= AN_OFF;
      segs <= SEGS_OFF;
    end
  end

  always_comb begin
    rd_data = '0;
    if (iobus_addr == VALUE_ADDR)     rd_data = {16'h0000, pend_val};
    else if (iobus_addr == CTRL_ADDR) rd_data = {26'h0, ctrl};
  end

endmodule
